// File: rtl/multicore_pkg.sv
// Shared multicore types: system-unit operations, data width and sysop arbiter state/trap codes.
package multicore_pkg;

    localparam int DATA_SIZE = 32;

    typedef enum logic [2:0] {
        RDCYCLE    = 3'd0,
        RDCYCLEH   = 3'd1,
        RDTIME     = 3'd2,
        RDTIMEH    = 3'd3,
        RDINSTRET  = 3'd4,
        RDINSTRETH = 3'd5,
        SCALL      = 3'd6,
        SBREAK     = 3'd7
    } t_sysop;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } t_sysop_arb_state;

    localparam logic [DATA_SIZE-1:0] SYSOP_TRAP_SCALL  = 1;
    localparam logic [DATA_SIZE-1:0] SYSOP_TRAP_SBREAK = 2;

    function automatic logic is_trap_op(input t_sysop op);
        return (op == SCALL) || (op == SBREAK);
    endfunction

endpackage

// File: rtl/sysop_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
// Zero latency; no state, so reusable by any shared-resource arbiter.
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/sysop_arbiter.sv
// Round-robin arbiter for the shared system unit: accept (cycle N), issue (N+1), respond (N+2, held until rsp ready).
// No new accepts while a request is in flight. Optional o_trap output under SYSOP_ARB_TRAP_EN.
module sysop_arbiter
    import multicore_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         i_aclk,
    input  logic                         i_reset,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  t_sysop [NUM_REQ-1:0]         i_req_op,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    output logic [DATA_SIZE-1:0]         o_rsp_data,
    input  logic [NUM_REQ-1:0]           i_rsp_ready,
    output t_sysop                       o_op,
    input  logic [DATA_SIZE-1:0]         i_result
`ifdef SYSOP_ARB_TRAP_EN
    ,
    output logic [NUM_REQ-1:0]           o_trap
`endif
);

    t_sysop_arb_state state, state_nxt;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      id_q;
    t_sysop               op_q;
    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] issue_data;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] id_onehot;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign id_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;

    // Trap ops never use the unit's result; they complete with a trap code (or zero).
    always_comb begin
        issue_data = i_result;
        if (is_trap_op(op_q)) begin
`ifdef SYSOP_ARB_TRAP_EN
            issue_data = (op_q == SCALL) ? SYSOP_TRAP_SCALL : SYSOP_TRAP_SBREAK;
`else
            issue_data = '0;
`endif
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state  <= IDLE;
            ptr    <= '0;
            id_q   <= '0;
            op_q   <= RDCYCLE;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (pick_any) begin
                    op_q <= i_req_op[pick_idx];
                    id_q <= pick_idx;
                end
                ISSUE: data_q <= issue_data;
                RESP: if (i_rsp_ready[id_q]) begin
                    ptr <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (i_rsp_ready[id_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == IDLE) ? pick_grant : '0;
        o_rsp_valid = (state == RESP) ? id_onehot : '0;
        o_rsp_data  = (state == RESP) ? data_q : '0;
        o_op        = op_q;
`ifdef SYSOP_ARB_TRAP_EN
        o_trap      = (state == ISSUE && is_trap_op(op_q)) ? id_onehot : '0;
`endif
    end

endmodule

// File: tb/tb_sysop_arbiter.sv
// Directed bench for sysop_arbiter: single request, stall, mid-op reset, round-robin order, wrap, trap ops.
module tb_sysop_arbiter;
    import multicore_pkg::*;

    logic                 i_aclk;
    logic                 i_reset;
    logic [3:0]           i_req_valid;
    t_sysop [3:0]         i_req_op;
    logic [3:0]           o_req_ready;
    logic [3:0]           o_rsp_valid;
    logic [DATA_SIZE-1:0] o_rsp_data;
    logic [3:0]           i_rsp_ready;
    t_sysop               o_op;
    logic [DATA_SIZE-1:0] i_result;
`ifdef SYSOP_ARB_TRAP_EN
    logic [3:0]           o_trap;
    localparam logic [63:0] EXP_SCALL = 64'd1;
    localparam logic [63:0] EXP_SBRK  = 64'd2;
`else
    localparam logic [63:0] EXP_SCALL = 64'd0;
    localparam logic [63:0] EXP_SBRK  = 64'd0;
`endif

    int total = 0;
    int bad   = 0;

    sysop_arbiter #(.NUM_REQ(4)) dut (
        .i_aclk      (i_aclk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_op    (i_req_op),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .i_rsp_ready (i_rsp_ready),
        .o_op        (o_op),
        .i_result    (i_result)
`ifdef SYSOP_ARB_TRAP_EN
        ,
        .o_trap      (o_trap)
`endif
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_aclk);
        #1;
    endtask

    // Requester-side protocol: a pending valid and its op must hold until accepted.
    logic [3:0]   prev_pend = '0;
    t_sysop [3:0] prev_op;
    logic         prev_rst  = 1'b1;
    always @(posedge i_aclk) begin
        if (!i_reset && !prev_rst) begin
            for (int i = 0; i < 4; i++) begin
                if (prev_pend[i]) begin
                    chk("proto_vld", 64'(i_req_valid[i]), 64'd1);
                    chk("proto_op", 64'(i_req_op[i]), 64'(prev_op[i]));
                end
            end
        end
        prev_pend <= i_req_valid & ~o_req_ready;
        prev_op   <= i_req_op;
        prev_rst  <= i_reset;
    end

    logic [3:0] exp_g;

    initial begin
        i_reset     = 1'b1;
        i_req_valid = '0;
        i_req_op    = {RDCYCLE, RDCYCLE, RDCYCLE, RDCYCLE};
        i_rsp_ready = '0;
        i_result    = '0;
        repeat (2) step();
        chk("rst_rdy",  64'(o_req_ready), 64'd0);
        chk("rst_rv",   64'(o_rsp_valid), 64'd0);
        chk("rst_dat",  64'(o_rsp_data),  64'd0);
        chk("rst_op",   64'(o_op),        64'(RDCYCLE));
        i_reset = 1'b0;

        // single request from requester 2
        i_result    = 32'h1234;
        i_req_valid = 4'b0100;
        #1 chk("t1_rdy", 64'(o_req_ready), 64'b0100);
        step();
        i_req_valid = '0;
        #1 chk("t1_op", 64'(o_op), 64'(RDCYCLE));
        chk("t1_rv_issue", 64'(o_rsp_valid), 64'd0);
`ifdef SYSOP_ARB_TRAP_EN
        chk("t1_trap", 64'(o_trap), 64'd0);
`endif
        step();
        #1 chk("t1_rv", 64'(o_rsp_valid), 64'b0100);
        chk("t1_dat", 64'(o_rsp_data), 64'h1234);
        i_rsp_ready = 4'b0100;
        step();
        i_rsp_ready = '0;
        #1 chk("t1_idle", 64'(o_rsp_valid), 64'd0);

        // response stall on requester 1; pointer is 3 so search wraps to 1
        i_req_op[1] = RDTIMEH;
        i_result    = 32'hA5;
        i_req_valid = 4'b0010;
        #1 chk("st_rdy", 64'(o_req_ready), 64'b0010);
        step();
        i_req_valid = '0;
        #1 chk("st_op", 64'(o_op), 64'(RDTIMEH));
        step();
        i_result    = 32'h0;
        i_rsp_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("st_rv%0d", k), 64'(o_rsp_valid), 64'b0010);
            chk($sformatf("st_dat%0d", k), 64'(o_rsp_data), 64'hA5);
            chk($sformatf("st_rdy%0d", k), 64'(o_req_ready), 64'd0);
            step();
        end
        i_rsp_ready = 4'b0010;
        step();
        i_rsp_ready = '0;
        #1 chk("st_idle", 64'(o_rsp_valid), 64'd0);

        // reset while in ISSUE
        i_req_op[3] = RDINSTRET;
        i_req_valid = 4'b1000;
        #1 chk("mr_rdy", 64'(o_req_ready), 64'b1000);
        step();
        i_req_valid = '0;
        #1 chk("mr_op", 64'(o_op), 64'(RDINSTRET));
        i_reset = 1'b1;
        step();
        chk("mr_rdy0", 64'(o_req_ready), 64'd0);
        chk("mr_rv0",  64'(o_rsp_valid), 64'd0);
        chk("mr_dat0", 64'(o_rsp_data),  64'd0);
        chk("mr_op0",  64'(o_op),        64'(RDCYCLE));
        i_reset = 1'b0;

        // round robin with all four requesting continuously
        i_result    = 32'h55;
        i_req_op    = {RDTIME, RDCYCLEH, RDINSTRETH, RDTIMEH};
        i_req_valid = 4'b1111;
        i_rsp_ready = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            exp_g = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            #1 chk($sformatf("rr_rdy%0d", c), 64'(o_req_ready), 64'(exp_g));
            if (c % 3 == 2) begin
                chk($sformatf("rr_rv%0d", c), 64'(o_rsp_valid), 64'(4'b0001 << ((c / 3) % 4)));
                chk($sformatf("rr_dat%0d", c), 64'(o_rsp_data), 64'h55);
            end
            step();
        end
        i_reset     = 1'b1;
        i_req_valid = '0;
        step();
        i_reset = 1'b0;

        // pointer wrap: grant 2 leaves pointer at 3, then 3 wins before 0
        i_req_valid = 4'b0100;
        #1 chk("wr_g2", 64'(o_req_ready), 64'b0100);
        step();
        i_req_valid = '0;
        step();
        step();
        i_req_valid = 4'b1001;
        #1 chk("wr_g3", 64'(o_req_ready), 64'b1000);
        step();
        i_req_valid = 4'b0001;
        step();
        step();
        #1 chk("wr_g0", 64'(o_req_ready), 64'b0001);
        step();
        i_req_valid = '0;
        step();
        step();

        // trap ops: SCALL from 0 (pointer 1 wraps to 0), then SBREAK from 1
        i_result    = 32'h77;
        i_req_op[0] = SCALL;
        i_req_valid = 4'b0001;
        #1 chk("sc_rdy", 64'(o_req_ready), 64'b0001);
        step();
        i_req_valid = '0;
        #1 chk("sc_op", 64'(o_op), 64'(SCALL));
`ifdef SYSOP_ARB_TRAP_EN
        chk("sc_trap", 64'(o_trap), 64'b0001);
`endif
        step();
        #1 chk("sc_dat", 64'(o_rsp_data), EXP_SCALL);
        chk("sc_rv", 64'(o_rsp_valid), 64'b0001);
`ifdef SYSOP_ARB_TRAP_EN
        chk("sc_trap_off", 64'(o_trap), 64'd0);
`endif
        step();
        i_req_op[1] = SBREAK;
        i_req_valid = 4'b0010;
        #1 chk("sb_rdy", 64'(o_req_ready), 64'b0010);
        step();
        i_req_valid = '0;
`ifdef SYSOP_ARB_TRAP_EN
        #1 chk("sb_trap", 64'(o_trap), 64'b0010);
`endif
        step();
        #1 chk("sb_dat", 64'(o_rsp_data), EXP_SBRK);
        step();
        #1 chk("sb_idle", 64'(o_rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysop_arbiter.md
Name: sysop_arbiter

Overview:
- Shares the single SYSTEM execution unit (cycle/time/instret counters, SCALL/SBREAK) between NUM_REQ requesters (cores or hardware threads).
- Sequences each request as accept, then issue, then respond.
- Arbitration is round-robin; each requester has valid/ready request and response handshakes.
- Sits between the execute stages of all cores and the one shared system unit instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the requester index (derived, not overridable).

Ports:
- i_aclk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_op  in  NUM_REQ x t_sysop  per-requester system operation.
- o_req_ready  out  NUM_REQ  one-hot accept; at most one bit set per cycle.
- o_rsp_valid  out  NUM_REQ  one-hot response valid.
- o_rsp_data  out  DATA_SIZE  response data, shared by all requesters and qualified by o_rsp_valid.
- i_rsp_ready  in  NUM_REQ  per-requester response accept.
- o_op  out  t_sysop  operation driven to the system unit.
- i_result  in  DATA_SIZE  combinational result from the system unit.

Behaviour:
- Reset (i_reset high at a clock edge):
  - state goes to IDLE and the RR pointer to 0.
  - o_req_ready, o_rsp_valid and o_rsp_data are all 0; o_op is RDCYCLE.
  - Reset mid-transaction silently drops the in-flight request and response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any i_req_valid is set, pick the winner: the first set bit at or after the pointer, searching with wrap-around.
  - o_req_ready[winner]=1 combinationally in the same cycle.
  - Latch the winner's op into op_q and its index into id_q, then go to ISSUE.
  - With no valid request, stay in IDLE with o_req_ready=0.
- ISSUE:
  - o_op=op_q.
  - Register data_q <= i_result; for SCALL/SBREAK register data_q <= 0 instead.
  - Go to RESP.
- RESP:
  - o_rsp_valid[id_q]=1 and o_rsp_data=data_q, both held stable until i_rsp_ready[id_q]=1.
  - On that handshake: pointer <= (id_q+1) mod NUM_REQ, then go to IDLE.
  - i_rsp_ready bits for other requesters are ignored.
- o_op holds op_q in all states; it is changed only by a new accept.
- Latency:
  - Accept at cycle N, response valid at N+2.
  - Minimum back-to-back throughput is one request per 3 cycles.
- Requests are not accepted in ISSUE or RESP; o_req_ready is 0 there.
- Requester protocol:
  - Valid and op must stay stable until ready is seen; the bench asserts this.
  - A requester may re-request in the cycle after its response handshake.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 grants.
- Pointer wrap: after a grant to NUM_REQ-1, the pointer goes to 0.
- When i_reset and a response handshake coincide, reset wins.
- Single-requester case: back-to-back grants to the same index are legal when no other requester is valid.

Optional Feature:
- Macro: SYSOP_ARB_TRAP_EN.
- Defined:
  - Adds output o_trap (NUM_REQ), one-hot.
  - In ISSUE for SCALL/SBREAK: o_trap[id_q] pulses high for exactly one cycle.
  - The following RESP has o_rsp_data=1 for SCALL and 2 for SBREAK.
- Undefined:
  - The o_trap port is absent.
  - SCALL/SBREAK complete with o_rsp_data=0.

Decomposition:
- Shared package multicore_pkg (existing): t_sysop, DATA_SIZE.
- Add to the package: t_sysop_arb_state enum {IDLE, ISSUE, RESP}, and constants SYSOP_TRAP_SCALL=1, SYSOP_TRAP_SBREAK=2.
- One sub-module, rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: request vector and pointer. Outputs: one-hot grant and index.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: reset, then req[2] valid with RDCYCLE, i_result stub=0x1234 → ready[2] at cycle 0, o_op=RDCYCLE at cycle 1, rsp_valid[2] with data 0x1234 at cycle 2.
- Round-robin: all 4 requesters valid continuously, rsp_ready tied 1 → grant order 0,1,2,3,0; a new grant every 3 cycles.
- Response stall: req[1] RDTIMEH, result 0xA5, rsp_ready[1] held low for 5 cycles → rsp_valid[1] and data 0xA5 stable for 5 cycles; no ready pulses; IDLE on the 6th cycle.
- Mid-operation reset: i_reset asserted in ISSUE → next cycle all outputs 0, o_op=RDCYCLE; the next grant goes to the lowest valid index.
- Pointer wrap: pointer=3 with req[0] and req[3] valid → grant 3, then grant 0.
- SCALL: with SYSOP_ARB_TRAP_EN, req[0] SCALL → o_trap[0] high for 1 cycle, rsp data 1. Without the macro → rsp data 0.
